// File: rtl/seq_arith_pkg.sv
// Shared definitions for the sequential arithmetic blocks.
//   state_t  : FSM state encoding used by the nibble-serial subtractor
//   NIBBLE_W : width of the slice processed per cycle
//   sub_ovf  : two's-complement overflow rule for a subtraction
package seq_arith_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam int NIBBLE_W = 4;

   // Signed overflow of a - b: operands of opposite sign and the result
   // sign differs from the minuend sign.
   function automatic logic sub_ovf(input logic a_msb, input logic b_msb,
                                    input logic d_msb);
      return (a_msb != b_msb) && (d_msb != a_msb);
   endfunction

endpackage

// File: rtl/cla_sub4.sv
// 4-bit carry-lookahead subtract slice: d = a - b - bin (mod 16).
// Ports:
//   a, b  : 4-bit minuend / subtrahend nibble
//   bin   : borrow-in
//   d     : 4-bit difference nibble
//   bout  : borrow-out
// Subtraction is done as a + ~b + ~bin, so the carry chain uses
// p = a ^ ~b, g = a & ~b and carry-in = ~bin; borrow-out = ~carry-out.
module cla_sub4
   import seq_arith_pkg::*;
(
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       bin,
   output logic [3:0] d,
   output logic       bout
);

   logic [3:0] p_s;
   logic [3:0] g_s;
   logic [4:0] c_s;

   assign p_s = a ^ ~b;
   assign g_s = a & ~b;

   // Every carry is expanded from c0 directly, so no carry waits on another.
   assign c_s[0] = ~bin;
   assign c_s[1] = g_s[0] | (p_s[0] & c_s[0]);
   assign c_s[2] = g_s[1] | (p_s[1] & g_s[0]) | (p_s[1] & p_s[0] & c_s[0]);
   assign c_s[3] = g_s[2] | (p_s[2] & g_s[1]) | (p_s[2] & p_s[1] & g_s[0])
                 | (p_s[2] & p_s[1] & p_s[0] & c_s[0]);
   assign c_s[4] = g_s[3] | (p_s[3] & g_s[2]) | (p_s[3] & p_s[2] & g_s[1])
                 | (p_s[3] & p_s[2] & p_s[1] & g_s[0])
                 | (p_s[3] & p_s[2] & p_s[1] & p_s[0] & c_s[0]);

   assign d    = p_s ^ c_s[3:0];
   assign bout = ~c_s[4];

endmodule

// File: rtl/seq_cla_subtractor.sv
// Nibble-serial subtractor: computes a - b - bin one 4-bit slice per cycle,
// LSB nibble first, through a single carry-lookahead slice.
// Ports:
//   clk, rst             : clock and synchronous active-high reset
//   in_valid / in_ready  : operand handshake (ready only while idle)
//   a, b, bin            : minuend, subtrahend, borrow-in
//   out_valid / out_ready: result handshake (valid only when done)
//   diff                 : a - b - bin modulo 2^WIDTH
//   bout                 : unsigned borrow-out (a < b + bin)
//   ovf                  : two's-complement overflow
// WIDTH must be a multiple of 4. Result appears WIDTH/4 cycles after accept.
module seq_cla_subtractor
   import seq_arith_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] diff,
   output logic             bout,
   output logic             ovf
);

   localparam int NIB_CNT = WIDTH / NIBBLE_W;
   localparam int CNT_W   = (NIB_CNT > 1) ? $clog2(NIB_CNT) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NIB_CNT - 1);

   state_t           state_r;
   logic [CNT_W-1:0] cnt_r;
   logic [WIDTH-1:0] a_r;
   logic [WIDTH-1:0] b_r;
   logic [WIDTH-1:0] diff_r;
   logic             borrow_r;
   logic             bout_r;
   logic             ovf_r;

   logic [CNT_W+1:0] nib_lsb_s;
   logic [3:0]       a_nib_s;
   logic [3:0]       b_nib_s;
   logic [3:0]       d_nib_s;
   logic             bout_nib_s;

   // Bit offset of the current nibble (cnt * 4).
   assign nib_lsb_s = {cnt_r, 2'b00};
   assign a_nib_s   = 4'(a_r >> nib_lsb_s);
   assign b_nib_s   = 4'(b_r >> nib_lsb_s);

   cla_sub4 u_slice (
      .a    (a_nib_s),
      .b    (b_nib_s),
      .bin  (borrow_r),
      .d    (d_nib_s),
      .bout (bout_nib_s)
   );

   assign in_ready  = (state_r == ST_IDLE);
   assign out_valid = (state_r == ST_DONE);
   assign diff      = diff_r;
   assign bout      = bout_r;
   assign ovf       = ovf_r;

   // Control FSM and nibble datapath registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r  <= ST_IDLE;
         cnt_r    <= {CNT_W{1'b0}};
         a_r      <= {WIDTH{1'b0}};
         b_r      <= {WIDTH{1'b0}};
         diff_r   <= {WIDTH{1'b0}};
         borrow_r <= 1'b0;
         bout_r   <= 1'b0;
         ovf_r    <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (in_valid) begin
                  a_r      <= a;
                  b_r      <= b;
                  // Captured borrow-in feeds the first nibble.
                  borrow_r <= bin;
                  cnt_r    <= {CNT_W{1'b0}};
                  state_r  <= ST_RUN;
               end else begin
                  state_r  <= ST_IDLE;
               end
            end
            ST_RUN: begin
               diff_r[nib_lsb_s +: NIBBLE_W] <= d_nib_s;
               borrow_r <= bout_nib_s;
               if (cnt_r == LAST_CNT) begin
                  bout_r  <= bout_nib_s;
                  // The final nibble carries the result sign bit.
                  ovf_r   <= sub_ovf(a_r[WIDTH-1], b_r[WIDTH-1], d_nib_s[3]);
                  state_r <= ST_DONE;
               end else begin
                  cnt_r   <= cnt_r + CNT_W'(1);
                  state_r <= ST_RUN;
               end
            end
            ST_DONE: begin
               if (out_ready) begin
                  state_r <= ST_IDLE;
               end else begin
                  state_r <= ST_DONE;
               end
            end
            default: begin
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_seq_cla_subtractor.sv
// Self-checking bench for seq_cla_subtractor (WIDTH = 16): directed corner
// cases, a reset abort and randomized operands against an arithmetic model.
module tb_seq_cla_subtractor;

   localparam int W = 16;

   logic         clk;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         bin;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] diff;
   logic         bout;
   logic         ovf;

   int ncomp = 0;
   int nfail = 0;

   seq_cla_subtractor #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .bin       (bin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .diff      (diff),
      .bout      (bout),
      .ovf       (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      ncomp++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference: plain integer arithmetic on unsigned and signed views.
   function automatic void model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                 input logic mbin, output logic [W-1:0] md,
                                 output logic mbo, output logic mov);
      int ua, ub, ur, sa, sb, sr;
      ua  = int'(ma);
      ub  = int'(mb);
      ur  = ua - ub - int'(mbin) + 65536;
      md  = ur[W-1:0];
      mbo = (ua < ub + int'(mbin));
      sa  = int'($signed(ma));
      sb  = int'($signed(mb));
      sr  = sa - sb - int'(mbin);
      mov = (sr > 32767) || (sr < -32768);
   endfunction

   // One full transaction: accept, latency, result, optional hold, handoff.
   task automatic run_op(input logic [W-1:0] oa, input logic [W-1:0] ob,
                         input logic obin, input int hold, input bit pulse);
      logic [W-1:0] ed;
      logic         ebo, eov;
      int           t;
      int           lat;
      model(oa, ob, obin, ed, ebo, eov);
      t = 0;
      while (!in_ready && t < 20) begin
         @(posedge clk); #1; t++;
      end
      check("ready_before_accept", 32'(in_ready), 32'd1);
      @(negedge clk);
      in_valid = 1'b1; a = oa; b = ob; bin = obin;
      @(posedge clk); #1;
      in_valid = 1'b0; a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
      check("in_ready_in_run", 32'(in_ready), 32'd0);
      lat = 0;
      while (!out_valid && lat < 20) begin
         @(posedge clk); #1; lat++;
      end
      check("latency", 32'(lat), 32'd4);
      check("diff", 32'(diff), 32'(ed));
      check("bout", 32'(bout), 32'(ebo));
      check("ovf", 32'(ovf), 32'(eov));
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         if (pulse) begin
            in_valid = 1'b1; a = W'($urandom); b = W'($urandom); bin = 1'b1;
         end
         @(posedge clk); #1;
         in_valid = 1'b0;
         check("hold_valid", 32'(out_valid), 32'd1);
         check("hold_in_ready", 32'(in_ready), 32'd0);
         check("hold_diff", 32'(diff), 32'(ed));
         check("hold_bout", 32'(bout), 32'(ebo));
      end
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check("handoff_valid_low", 32'(out_valid), 32'd0);
      check("handoff_idle", 32'(in_ready), 32'd1);
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; bin = 1'b0; out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_diff", 32'(diff), 32'd0);
      check("rst_bout", 32'(bout), 32'd0);
      check("rst_ovf", 32'(ovf), 32'd0);
      @(negedge clk);
      rst = 1'b0;

      // Directed corner cases.
      run_op(16'h1234, 16'h0234, 1'b0, 0, 1'b0);
      run_op(16'h0000, 16'h0001, 1'b0, 0, 1'b0);
      run_op(16'h8000, 16'h0001, 1'b0, 0, 1'b0);
      run_op(16'h7FFF, 16'hFFFF, 1'b0, 0, 1'b0);
      run_op(16'h1234, 16'h1233, 1'b1, 3, 1'b1);
      run_op(16'h7FFF, 16'h8000, 1'b1, 1, 1'b0);

      // Reset during the second RUN cycle aborts the operation.
      @(negedge clk);
      in_valid = 1'b1; a = 16'hABCD; b = 16'h1111; bin = 1'b0;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
      check("abort_in_ready", 32'(in_ready), 32'd1);
      check("abort_out_valid", 32'(out_valid), 32'd0);
      check("abort_diff", 32'(diff), 32'd0);
      check("abort_bout", 32'(bout), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         check("abort_no_valid", 32'(out_valid), 32'd0);
      end
      run_op(16'h0005, 16'h0003, 1'b0, 0, 1'b0);

      // Randomized operands.
      for (int i = 0; i < 24; i++) begin
         run_op(W'($urandom), W'($urandom), 1'($urandom),
                int'($urandom_range(0, 2)), 1'($urandom));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
      $finish;
   end

endmodule

// File: doc/seq_cla_subtractor.md
SEQ_CLA_SUBTRACTOR -- requirements
Module: seq_cla_subtractor

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand width, which SHALL be a multiple of 4.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, synchronous active-high reset, sampled on the clk rising edge.
REQ-004 SHALL have port in_valid, input, 1, operands a, b and bin are valid this cycle.
REQ-005 SHALL have port in_ready, output, 1, block can accept operands this cycle.
REQ-006 SHALL have port a, input, WIDTH, minuend.
REQ-007 SHALL have port b, input, WIDTH, subtrahend.
REQ-008 SHALL have port bin, input, 1, borrow-in.
REQ-009 SHALL have port out_valid, output, 1, result valid.
REQ-010 SHALL have port out_ready, input, 1, consumer accepts the result.
REQ-011 SHALL have port diff, output, WIDTH, result a - b - bin modulo 2^WIDTH.
REQ-012 SHALL have port bout, output, 1, unsigned borrow-out (1 when a < b + bin).
REQ-013 SHALL have port ovf, output, 1, two's-complement signed overflow.

Function
REQ-014 SHALL implement a three-state FSM: IDLE, RUN, DONE.
REQ-015 SHALL drive in_ready = 1 in IDLE only and out_valid = 1 in DONE only, both decoded from the state register.
REQ-016 SHALL accept operands when in_valid && in_ready, registering a, b and bin, clearing the nibble counter and entering RUN.
REQ-017 SHALL, in RUN, process one 4-bit nibble per cycle, LSB nibble first, through a carry-lookahead subtract slice (p = a ^ ~b, g = a & ~b, carry-in = ~borrow), with every carry computed in lookahead form, not rippled.
REQ-018 SHALL register the slice borrow-out each RUN cycle and use it as the next nibble's borrow-in; the first nibble uses the captured bin.
REQ-019 SHALL write each nibble result into its position in the diff register.
REQ-020 SHALL move to DONE after the nibble with index WIDTH/4 - 1, so out_valid rises exactly WIDTH/4 cycles after the accept edge (4 cycles at the default width).
REQ-021 SHALL set bout to the final nibble's borrow-out.
REQ-022 SHALL set ovf = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]) using the captured operands.
REQ-023 SHALL hold diff, bout and ovf stable while in DONE with out_ready = 0, for any number of cycles.
REQ-024 SHALL return to IDLE on the cycle after out_valid && out_ready.
REQ-025 SHALL NOT accept new operands in the same cycle as result handoff; the minimum issue interval is WIDTH/4 + 2 cycles.
REQ-026 SHALL ignore in_valid, a, b and bin outside IDLE.

Reset
REQ-027 SHALL, on rst, force state to IDLE, the counter, diff, bout, ovf and the borrow register to 0, in_ready to 1 and out_valid to 0.
REQ-028 SHALL give rst priority over all other events: rst asserted in RUN or DONE aborts the operation, discards the result, and produces no out_valid pulse.

Structure
REQ-029 SHALL place the FSM state encoding and the nibble width constant (4) in the shared package seq_arith_pkg.
REQ-030 SHALL implement the nibble datapath as one combinational sub-module, cla_sub4 (ports a[3:0], b[3:0], bin, d[3:0], bout), instantiated once.

Verification
REQ-031 SHALL cover: a=0x1234, b=0x0234, bin=0 -> diff=0x1000, bout=0, ovf=0, out_valid 4 cycles after accept.
REQ-032 SHALL cover: a=0x0000, b=0x0001, bin=0 -> diff=0xFFFF, bout=1, ovf=0 (borrow propagating through all nibbles).
REQ-033 SHALL cover: a=0x8000, b=0x0001, bin=0 -> diff=0x7FFF, bout=0, ovf=1; and a=0x7FFF, b=0xFFFF -> diff=0x8000, bout=1, ovf=1.
REQ-034 SHALL cover: a=0x1234, b=0x1233, bin=1 -> diff=0x0000, bout=0; with out_ready held low 3 cycles, diff stays stable and in_ready stays 0; in_valid pulsed in DONE is ignored.
REQ-035 SHALL cover: rst asserted on the 2nd RUN cycle -> next cycle IDLE, in_ready=1, out_valid=0, diff=0, and a following 0x0005-0x0003 returns 0x0002.
